// File: rtl/tone_decoder.sv
// ============================================================================
// tone_decoder : measures and locks onto the half-period of a square wave.
// Optional glitch rejection of edges closer than MIN_HALF: TONE_DEC_GLITCH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tone_decoder #(
  parameter int CNT_W       = 22,
  parameter int TIMEOUT_CYC = 4000000,
  parameter int LOCK_N      = 3,
  parameter int TOL         = 1,
  parameter int MIN_HALF    = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tone_i,
  output logic             active_o,
  output logic [CNT_W-1:0] half_per_o,
  output logic             upd_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    TRACK = 2'd2,
    LOCK  = 2'd3
  } state_t;

  if ((LOCK_N < 1) || (LOCK_N > 15) || (MIN_HALF < 0) || (TOL < 0) ||
      (TIMEOUT_CYC < 1) || (longint'(TIMEOUT_CYC) >= (longint'(1) << CNT_W))) begin : g_param_check
    $error("tone_decoder: parameter out of range");
  end

  state_t             state_q, state_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               sync3_q, sync3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   prev_q, prev_d;
  logic [3:0]         match_q, match_d;
  logic               active_q, active_d;
  logic [CNT_W-1:0]   half_per_q, half_per_d;
  logic               upd_q, upd_d;

  logic               tone_edge;
  logic               edge_ok;
  logic               timeout;
  logic [CNT_W:0]     diff;
  logic               is_match;
  logic [3:0]         match_inc;
  logic               lock_hit;

  assign tone_edge = sync2_q ^ sync3_q;

`ifdef TONE_DEC_GLITCH_EN
  // IDLE has no running count, so the first edge is always taken.
  assign edge_ok = tone_edge && ((state_q == IDLE) || (cnt_q >= CNT_W'(MIN_HALF)));
`else
  assign edge_ok = tone_edge;
`endif

  assign timeout   = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign match_inc = match_q + 4'd1;
  assign lock_hit  = (match_inc == 4'(LOCK_N));
  assign is_match  = (diff <= (CNT_W+1)'(TOL));

  always_comb begin
    diff = '0;
    if (cnt_q >= prev_q) begin
      diff = {1'b0, cnt_q} - {1'b0, prev_q};
    end else begin
      diff = {1'b0, prev_q} - {1'b0, cnt_q};
    end
  end

  always_comb begin
    state_d    = state_q;
    sync1_d    = tone_i;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    match_d    = match_q;
    active_d   = active_q;
    half_per_d = half_per_q;
    upd_d      = 1'b0;

    if (state_q == IDLE) begin
      cnt_d = '0;
      if (edge_ok) begin
        state_d = ARM;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
      if (timeout) begin
        state_d    = IDLE;
        cnt_d      = '0;
        active_d   = 1'b0;
        half_per_d = '0;
        match_d    = '0;
      end else if (edge_ok) begin
        // cnt_q is the measurement: cycle distance since the last accepted edge.
        cnt_d  = CNT_W'(1);
        prev_d = cnt_q;
        case (state_q)
          ARM: begin
            match_d = '0;
            state_d = TRACK;
          end
          TRACK: begin
            if (is_match) begin
              match_d = match_inc;
              if (lock_hit) begin
                state_d    = LOCK;
                half_per_d = cnt_q;
                active_d   = 1'b1;
                upd_d      = 1'b1;
              end
            end else begin
              match_d = '0;
            end
          end
          LOCK: begin
            if (is_match) begin
              half_per_d = cnt_q;
              upd_d      = 1'b1;
            end else begin
              state_d    = TRACK;
              active_d   = 1'b0;
              half_per_d = '0;
              match_d    = '0;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      cnt_q      <= '0;
      prev_q     <= '0;
      match_q    <= '0;
      active_q   <= 1'b0;
      half_per_q <= '0;
      upd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      match_q    <= match_d;
      active_q   <= active_d;
      half_per_q <= half_per_d;
      upd_q      <= upd_d;
    end
  end

  assign active_o   = active_q;
  assign half_per_o = half_per_q;
  assign upd_o      = upd_q;

endmodule

`default_nettype wire
